// File: rtl/game_controller.sv
// Puzzle sequencer: board selection, swap application, move counting, solve detection.
// Latency: swap visible 1 cycle after swap_req, WINNED 1 cycle after a solved board is visible.
// Backpressure: none; pulses arriving in states that ignore them are dropped.
// Optional move limit enabled by defining GAME_MOVE_LIMIT_EN.
module game_controller #(
   parameter int          MOVE_W    = 7,
   parameter int          MAX_MOVES = 99,
   parameter logic [11:0] SOLVED    = 12'b000_001_010_011
) (
   input  logic              clk_d,
   input  logic              rst,
   input  logic              confirm,
   input  logic              abort,
   input  logic              swap_req,
   input  logic [1:0]        swap_a,
   input  logic [1:0]        swap_b,
   input  logic [11:0]       board_in,
   output logic [1:0]        game_status,
   output logic [11:0]       board,
   output logic [MOVE_W-1:0] move_cnt,
   output logic              swap_ack,
   output logic              win,
   output logic              lost
);

   // State encoding doubles as the game_status code driven to the board generator.
   typedef enum logic [1:0] {
      CHOSE_BOARD  = 2'b00,
      GAME_INITIAL = 2'b10,
      GAMING       = 2'b01,
      WINNED       = 2'b11
   } state_t;

`ifdef GAME_MOVE_LIMIT_EN
   localparam bit LIMIT_ON = 1'b1;
`else
   localparam bit LIMIT_ON = 1'b0;
`endif
   localparam logic [MOVE_W-1:0] MAX_CNT = MOVE_W'(MAX_MOVES);
   localparam logic [MOVE_W-1:0] SAT_CNT = {MOVE_W{1'b1}};

   state_t            state, state_nxt;
   logic [11:0]       board_nxt, board_swapped;
   logic [MOVE_W-1:0] cnt_nxt, cnt_inc;
   logic [3:0]        pos_a, pos_b;
   logic              ack_nxt, lost_nxt, swap_ok;

   // Candidate board with slots swap_a/swap_b exchanged, plus saturating move count.
   always_comb begin
      pos_a         = 4'd11 - 4'd3 * {2'b00, swap_a};
      pos_b         = 4'd11 - 4'd3 * {2'b00, swap_b};
      board_swapped = board;
      board_swapped[pos_a -: 3] = board[pos_b -: 3];
      board_swapped[pos_b -: 3] = board[pos_a -: 3];
      swap_ok       = swap_req && (swap_a != swap_b);
      cnt_inc       = (move_cnt == SAT_CNT) ? move_cnt : move_cnt + MOVE_W'(1);
   end

   // Next-state and next-output decode; abort outranks swaps while playing.
   always_comb begin
      state_nxt = state;
      board_nxt = board;
      cnt_nxt   = move_cnt;
      ack_nxt   = 1'b0;
      lost_nxt  = 1'b0;
      case (state)
         CHOSE_BOARD: begin
            board_nxt = board_in;
            if (confirm) state_nxt = GAME_INITIAL;
         end
         GAME_INITIAL: begin
            board_nxt = board_in;
            cnt_nxt   = '0;
            state_nxt = GAMING;
         end
         GAMING: begin
            if (abort) begin
               state_nxt = CHOSE_BOARD;
            end else begin
               // Solve check looks at the board already visible on the outputs.
               if (board == SOLVED) state_nxt = WINNED;
               if (swap_ok) begin
                  board_nxt = board_swapped;
                  cnt_nxt   = cnt_inc;
                  ack_nxt   = 1'b1;
                  // Limit only loses when the limiting swap does not solve the board.
                  if (LIMIT_ON && (cnt_inc == MAX_CNT) && (move_cnt != MAX_CNT) &&
                      (board_swapped != SOLVED) && (board != SOLVED)) begin
                     lost_nxt  = 1'b1;
                     state_nxt = CHOSE_BOARD;
                  end
               end
            end
         end
         WINNED: begin
            if (confirm || abort) state_nxt = CHOSE_BOARD;
         end
         default: state_nxt = CHOSE_BOARD;
      endcase
   end

   // State and registered outputs; rst wins over every input.
   always_ff @(posedge clk_d) begin
      if (rst) begin
         state    <= CHOSE_BOARD;
         board    <= SOLVED;
         move_cnt <= '0;
         swap_ack <= 1'b0;
         win      <= 1'b0;
         lost     <= 1'b0;
      end else begin
         state    <= state_nxt;
         board    <= board_nxt;
         move_cnt <= cnt_nxt;
         swap_ack <= ack_nxt;
         win      <= (state_nxt == WINNED);
         lost     <= lost_nxt;
      end
   end

   assign game_status = state;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed scenarios plus randomized play against a slot-array model.
module tb_game_controller;
   localparam int          MOVE_W  = 7;
   localparam int          MAXM    = 3;
   localparam int          CNT_MAX = (1 << MOVE_W) - 1;
   localparam logic [11:0] SOLVED_B = 12'b000_001_010_011;
   localparam logic [11:0] SWAP01_B = 12'b001_000_010_011;
   localparam logic [1:0]  S_CHOSE = 2'b00, S_INIT = 2'b10, S_PLAY = 2'b01, S_WON = 2'b11;
`ifdef GAME_MOVE_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   logic              clk_d = 1'b0;
   logic              rst = 1'b1, confirm = 1'b0, abort = 1'b0, swap_req = 1'b0;
   logic [1:0]        swap_a = 2'd0, swap_b = 2'd0;
   logic [11:0]       board_in = 12'd0;
   logic [1:0]        game_status;
   logic [11:0]       board;
   logic [MOVE_W-1:0] move_cnt;
   logic              swap_ack, win, lost;

   int n_cmp = 0, n_fail = 0;

   // reference model: game phase, four tile slots, move count and pulse flags
   logic [1:0] m_st;
   int         m_slot[4];
   int         m_cnt;
   bit         m_ack, m_win, m_lost;

   game_controller #(.MOVE_W(MOVE_W), .MAX_MOVES(MAXM), .SOLVED(SOLVED_B)) dut (
      .clk_d(clk_d), .rst(rst), .confirm(confirm), .abort(abort), .swap_req(swap_req),
      .swap_a(swap_a), .swap_b(swap_b), .board_in(board_in), .game_status(game_status),
      .board(board), .move_cnt(move_cnt), .swap_ack(swap_ack), .win(win), .lost(lost)
   );

   always #5 clk_d = ~clk_d;

   function automatic bit is_solved();
      for (int i = 0; i < 4; i++) if (m_slot[i] != i) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [23:0] exp_vec();
      logic [11:0] b = '0;
      for (int i = 0; i < 4; i++) b = {b[8:0], 3'(m_slot[i])};
      return {m_st, b, MOVE_W'(m_cnt), m_ack, m_win, m_lost};
   endfunction

   function automatic logic [23:0] dut_vec();
      return {game_status, board, move_cnt, swap_ack, win, lost};
   endfunction

   task automatic load(input logic [11:0] bin);
      for (int i = 0; i < 4; i++) m_slot[i] = int'(bin[11-3*i -: 3]);
   endtask

   task automatic model_update(input logic r, cf, ab, sr, input logic [1:0] a, b,
                               input logic [11:0] bin);
      bit solved_now;
      int t, prev;
      m_ack  = 1'b0;
      m_lost = 1'b0;
      if (r) begin
         m_st = S_CHOSE;
         for (int i = 0; i < 4; i++) m_slot[i] = i;
         m_cnt = 0;
      end else begin
         case (m_st)
            S_CHOSE: begin load(bin); if (cf) m_st = S_INIT; end
            S_INIT:  begin load(bin); m_cnt = 0; m_st = S_PLAY; end
            S_PLAY: begin
               if (ab) m_st = S_CHOSE;
               else begin
                  solved_now = is_solved();
                  if (solved_now) m_st = S_WON;
                  if (sr && a != b) begin
                     t = m_slot[a]; m_slot[a] = m_slot[b]; m_slot[b] = t;
                     prev = m_cnt;
                     if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                     m_ack = 1'b1;
                     if (LIMIT && !solved_now && !is_solved() && m_cnt == MAXM && prev != MAXM) begin
                        m_lost = 1'b1;
                        m_st   = S_CHOSE;
                     end
                  end
               end
            end
            default: if (cf || ab) m_st = S_CHOSE;
         endcase
      end
      m_win = (m_st == S_WON);
   endtask

   // drive one cycle of inputs, advance the model on the same edge, settle 1 time unit after
   task automatic step(input logic r, cf, ab, sr, input logic [1:0] a, b, input logic [11:0] bin);
      rst = r; confirm = cf; abort = ab; swap_req = sr; swap_a = a; swap_b = b; board_in = bin;
      @(posedge clk_d);
      model_update(r, cf, ab, sr, a, b, bin);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 12'($urandom));
         n_cmp++;
         if (dut_vec() !== {S_CHOSE, SOLVED_B, 7'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset[%0d]: got %h want %h", i, dut_vec(), {S_CHOSE, SOLVED_B, 7'd0, 3'b000});
         end
      end
   endtask

   task automatic test_one_swap_win();
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, SWAP01_B);   // confirm -> INIT
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, SWAP01_B);   // -> GAMING
      step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 12'd0);      // swap 0/1
      n_cmp++;
      if (dut_vec() !== {S_PLAY, SOLVED_B, 7'd1, 3'b100} || dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL swap_win_ack: got %h want %h", dut_vec(), exp_vec());
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 12'd0);
      n_cmp++;
      if (dut_vec() !== {S_WON, SOLVED_B, 7'd1, 3'b010}) begin
         n_fail++;
         $display("FAIL swap_win_won: got %h want %h", dut_vec(), {S_WON, SOLVED_B, 7'd1, 3'b010});
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 12'd0);      // leave win screen
      n_cmp++;
      if (dut_vec() !== exp_vec() || game_status !== S_CHOSE) begin
         n_fail++;
         $display("FAIL swap_win_exit: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic enter_game(input logic [11:0] bin);
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, bin);
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, bin);
   endtask

   task automatic test_same_slot_and_abort();
      enter_game(SWAP01_B);
      step(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 12'd0);
      n_cmp++;
      if (dut_vec() !== {S_PLAY, SWAP01_B, 7'd0, 3'b000} || dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL same_slot: got %h want %h", dut_vec(), exp_vec());
      end
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 12'd0);      // abort beats swap
      n_cmp++;
      if (dut_vec() !== {S_CHOSE, SWAP01_B, 7'd0, 3'b000} || dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL abort_priority: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_preloaded_solved();
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, SOLVED_B);
      n_cmp++;
      if (game_status !== S_INIT) begin
         n_fail++;
         $display("FAIL preload_init: got %b want %b", game_status, S_INIT);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, SOLVED_B);
      n_cmp++;
      if (game_status !== S_PLAY) begin
         n_fail++;
         $display("FAIL preload_play: got %b want %b", game_status, S_PLAY);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 12'd0);
      n_cmp++;
      if (dut_vec() !== {S_WON, SOLVED_B, 7'd0, 3'b010} || dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL preload_won: got %h want %h", dut_vec(), exp_vec());
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 12'd0);      // swap ignored on win screen
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 12'd0);
      n_cmp++;
      if (game_status !== S_CHOSE || dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL preload_exit: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_move_limit();
      enter_game(SWAP01_B);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd3, 12'd0);
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL limit_swap[%0d]: got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      n_cmp++;
`ifdef GAME_MOVE_LIMIT_EN
      if (lost !== 1'b1 || game_status !== S_CHOSE) begin
         n_fail++;
         $display("FAIL limit_lost: got lost=%b status=%b want 1/00", lost, game_status);
      end
`else
      if (lost !== 1'b0 || game_status !== S_PLAY || move_cnt !== 7'd3) begin
         n_fail++;
         $display("FAIL limit_none: got lost=%b status=%b cnt=%0d want 0/01/3", lost, game_status, move_cnt);
      end
`endif
      step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 12'd0);
   endtask

`ifndef GAME_MOVE_LIMIT_EN
   task automatic test_saturation();
      enter_game(SWAP01_B);
      for (int i = 0; i < CNT_MAX + 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd2, 12'd0);
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL saturate[%0d]: got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      n_cmp++;
      if (move_cnt !== 7'd127) begin
         n_fail++;
         $display("FAIL saturate_final: got %0d want 127", move_cnt);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 12'd0);
   endtask
`endif

   task automatic test_random();
      logic [11:0] bin;
      logic        sr;
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0: bin = SOLVED_B;
            1: bin = SWAP01_B;
            2: bin = 12'b000_001_011_010;
            default: bin = 12'($urandom);
         endcase
         sr = ($urandom_range(0, 1) == 1);
         if (m_st == S_PLAY && is_solved()) sr = 1'b0;
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
              sr, 2'($urandom), 2'($urandom), bin);
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_one_swap_win();
      test_same_slot_and_abort();
      test_preloaded_solved();
      test_move_limit();
`ifndef GAME_MOVE_LIMIT_EN
      test_saturation();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
